// File: rtl/fetch_unit.sv
// Multicycle instruction fetch stage: PC register, memory read strobe,
// instruction register with a valid/ready handshake to decode, and
// branch/jump redirects from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 28,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ir_ready,
  input  logic [31:0] instr,
  output logic [31:0] add,
  output logic        rd_i,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic        ir_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [29:0] DEPTH_W = 30'(ROM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAPT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] ir_pc4_q, ir_pc4_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic        in_range;

  assign in_range    = (pc_q[31:2] < DEPTH_W);
  assign add         = {2'b00, pc_q[31:2]};
  assign rd_i        = (state_q == REQ) && in_range;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_pc4      = ir_pc4_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;

  // Next-state: normal fetch sequencing, then redirect overrides it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_pc4_d   = ir_pc4_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (in_range) begin
          state_d = CAPT;
        end else begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      CAPT: begin
        // instr is only looked at here, so garbage elsewhere never reaches IR
        ir_d       = instr;
        ir_pc_d    = pc_q;
        ir_pc4_d   = pc_q + 32'd4;
        pc_d       = pc_q + 32'd4;
        ir_valid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          cnt_d      = cnt_q + 32'd1;
          state_d    = REQ;
        end
      end
      FAULT: begin
        fault_d    = 1'b1;
        ir_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A HOLD handshake already counted above still stands; everything else
    // from the normal path (including a CAPT load) is discarded.
    if (redirect) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d       = redirect_pc;
        ir_d       = NOP_INSTR;
        ir_pc_d    = ir_pc_q;
        ir_pc4_d   = ir_pc4_q;
        ir_valid_d = 1'b0;
        fault_d    = 1'b0;
        state_d    = REQ;
      end else begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_pc4_d   = ir_pc4_q;
        ir_valid_d = 1'b0;
        fault_d    = 1'b1;
        state_d    = FAULT;
      end
    end
  end

  // State register; reset wins over any redirect or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      ir_pc_q    <= 32'd0;
      ir_pc4_q   <= 32'd4;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_pc4_q   <= ir_pc4_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
